coherence_arbiter: RTL and testbench

Parametrised snoopy-bus coherence controller for an NCPU-core MSI system, sitting between the per-core data caches and the shared memory controller. It arbitrates coherence transactions among all cores and broadcasts snoop addresses to every non-owner cache. It invalidates sharers on write-intent transactions and moves each block as WORDS sequential words, sourced either cache-to-cache (dirty sharer) or from memory. Unlike the earlier two-core controller, it latches the owner and address per transaction, counts block words explicitly, and arbitrates fairly among N requesters.

---
 rtl/coherence_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_coherence_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_arbiter.sv
// Snoopy-bus MSI coherence arbiter: grants one core at a time, snoops the others, and moves a
// WORDS-word block from a dirty sharer or from memory. Define COH_RR_ARB_EN for round-robin grants.
module coherence_arbiter #(
  parameter int NCPU  = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int WORDS = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NCPU-1:0]    cctrans,
  input  logic [NCPU-1:0]    ccwrite,
  input  logic [NCPU*AW-1:0] daddr,
  input  logic [NCPU-1:0]    snoopdirty,
  input  logic [NCPU*DW-1:0] dstore,
  input  logic              memwait,
  input  logic [DW-1:0]     memload,
  output logic [NCPU-1:0]    ccwait,
  output logic [NCPU-1:0]    ccinv,
  output logic [AW-1:0]     ccsnoopaddr,
  output logic [AW-1:0]     xaddr,
  output logic [DW-1:0]     dload,
  output logic [NCPU-1:0]    dvalid,
  output logic [NCPU-1:0]    done,
  output logic              c2c,
  output logic              memreq
);

  localparam int OW = $clog2(NCPU);
  localparam int WW = $clog2(WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNOOP,
    S_C2C,
    S_MEM,
    S_INV
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [AW-1:0]   base_q, base_d;
  logic            write_q, write_d;
  logic [WW-1:0]   word_q, word_d;
  logic [OW-1:0]   src_q, src_d;

  logic            grant_vld;
  logic [OW-1:0]   grant_idx;
  logic            src_found;
  logic [OW-1:0]   src_idx;
  logic [NCPU-1:0] owner_oh;
  logic [NCPU-1:0] others;
  logic            word_last;
  logic [AW-1:0]   word_addr;
  logic [DW-1:0]   dstore_sel;

`ifdef COH_RR_ARB_EN
  logic [OW-1:0]   ptr_q, ptr_d;

  // Search starts just after the last owner, so a core that keeps requesting cannot starve others.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NCPU; k++) begin
      idx = int'(ptr_q) + 1 + k;
      if (idx >= NCPU) idx = idx - NCPU;
      if (!grant_vld && cctrans[idx]) begin
        grant_vld = 1'b1;
        grant_idx = OW'(idx);
      end
    end
  end
`else
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NCPU - 1; k >= 0; k--) begin
      if (cctrans[k]) begin
        grant_vld = 1'b1;
        grant_idx = OW'(k);
      end
    end
  end
`endif

  // Lowest-index dirty sharer other than the owner supplies the block.
  always_comb begin
    src_found = 1'b0;
    src_idx   = '0;
    for (int i = NCPU - 1; i >= 0; i--) begin
      if (snoopdirty[i] && (OW'(i) != owner_q)) begin
        src_found = 1'b1;
        src_idx   = OW'(i);
      end
    end
  end

  assign owner_oh   = NCPU'(1) << owner_q;
  assign others     = ~owner_oh;
  assign word_last  = (word_q == WW'(WORDS - 1));
  assign word_addr  = base_q + AW'({word_q, 2'b00});
  assign dstore_sel = dstore[src_q*DW +: DW];

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred; blocking '=' is correct inside combinational logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    write_d     = write_q;
    word_d      = word_q;
    src_d       = src_q;
`ifdef COH_RR_ARB_EN
    ptr_d       = ptr_q;
`endif
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    xaddr       = '0;
    dload       = '0;
    dvalid      = '0;
    done        = '0;
    c2c         = 1'b0;
    memreq      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          owner_d = grant_idx;
          base_d  = daddr[grant_idx*AW +: AW];
          write_d = ccwrite[grant_idx];
          word_d  = '0;
`ifdef COH_RR_ARB_EN
          ptr_d   = grant_idx;
`endif
          state_d = S_SNOOP;
        end
      end

      S_SNOOP: begin
        ccwait      = others;
        ccsnoopaddr = base_q;
        xaddr       = base_q;
        src_d       = src_idx;
        if (write_q)        state_d = S_INV;
        else if (src_found) state_d = S_C2C;
        else                state_d = S_MEM;
      end

      S_C2C: begin
        ccwait      = others;
        ccsnoopaddr = base_q;
        xaddr       = word_addr;
        c2c         = 1'b1;
        dload       = dstore_sel;
        if (!memwait) begin
          dvalid = owner_oh;
          if (word_last) begin
            word_d  = '0;
            done    = owner_oh;
            state_d = S_IDLE;
          end else begin
            word_d = word_q + WW'(1);
          end
        end
      end

      S_MEM: begin
        ccsnoopaddr = base_q;
        xaddr       = word_addr;
        memreq      = 1'b1;
        dload       = memload;
        if (!memwait) begin
          dvalid = owner_oh;
          if (word_last) begin
            word_d  = '0;
            done    = owner_oh;
            state_d = S_IDLE;
          end else begin
            word_d = word_q + WW'(1);
          end
        end
      end

      // A dirty sharer writes back through its own eviction path, so only invalidation happens here.
      S_INV: begin
        ccwait      = others;
        ccinv       = others;
        ccsnoopaddr = base_q;
        xaddr       = base_q;
        done        = owner_oh;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops update together at the edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      base_q  <= '0;
      write_q <= 1'b0;
      word_q  <= '0;
      src_q   <= '0;
`ifdef COH_RR_ARB_EN
      ptr_q   <= OW'(NCPU - 1);
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      write_q <= write_d;
      word_q  <= word_d;
      src_q   <= src_d;
`ifdef COH_RR_ARB_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_coherence_arbiter.sv
// Directed self-checking bench for coherence_arbiter with NCPU=4, WORDS=2.
module tb_coherence_arbiter;

  localparam int NCPU  = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int WORDS = 2;

  logic              CLK;
  logic              RST;
  logic [NCPU-1:0]    cctrans;
  logic [NCPU-1:0]    ccwrite;
  logic [NCPU*AW-1:0] daddr;
  logic [NCPU-1:0]    snoopdirty;
  logic [NCPU*DW-1:0] dstore;
  logic              memwait;
  logic [DW-1:0]     memload;
  logic [NCPU-1:0]    ccwait;
  logic [NCPU-1:0]    ccinv;
  logic [AW-1:0]     ccsnoopaddr;
  logic [AW-1:0]     xaddr;
  logic [DW-1:0]     dload;
  logic [NCPU-1:0]    dvalid;
  logic [NCPU-1:0]    done;
  logic              c2c;
  logic              memreq;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_grant [5];

  coherence_arbiter #(.NCPU(NCPU), .AW(AW), .DW(DW), .WORDS(WORDS)) dut (
    .CLK(CLK), .RST(RST),
    .cctrans(cctrans), .ccwrite(ccwrite), .daddr(daddr),
    .snoopdirty(snoopdirty), .dstore(dstore),
    .memwait(memwait), .memload(memload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .xaddr(xaddr),
    .dload(dload), .dvalid(dvalid), .done(done), .c2c(c2c), .memreq(memreq)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    daddr[i*AW +: AW] = a;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] d);
    dstore[i*DW +: DW] = d;
  endtask

  initial begin
`ifdef COH_RR_ARB_EN
    exp_grant = '{0, 1, 2, 3, 0};
`else
    exp_grant = '{0, 0, 0, 0, 0};
`endif
    RST        = 1'b1;
    cctrans    = '0;
    ccwrite    = '0;
    daddr      = '0;
    snoopdirty = '0;
    dstore     = '0;
    memwait    = 1'b0;
    memload    = 32'h1111_2222;
    #1;
    check("rst_ccwait", ccwait, 0);
    check("rst_done", done, 0);
    check("rst_memreq", memreq, 0);
    check("rst_xaddr", xaddr, 0);
    check("rst_dload", dload, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    tick();

    // Core 2 reads 0x100 from memory, no dirty sharers, zero wait.
    cctrans = 4'b0100;
    set_addr(2, 32'h100);
    #1;
    check("t1_idle_ccwait", ccwait, 0);
    check("t1_idle_snoopaddr", ccsnoopaddr, 0);
    tick();
    check("t1_snoop_ccwait", ccwait, 4'b1011);
    check("t1_snoop_addr", ccsnoopaddr, 32'h100);
    check("t1_snoop_memreq", memreq, 0);
    tick();
    check("t1_w0_memreq", memreq, 1);
    check("t1_w0_xaddr", xaddr, 32'h100);
    check("t1_w0_dvalid", dvalid, 4'b0100);
    check("t1_w0_dload", dload, 32'h1111_2222);
    check("t1_w0_done", done, 0);
    tick();
    check("t1_w1_xaddr", xaddr, 32'h104);
    check("t1_w1_dvalid", dvalid, 4'b0100);
    check("t1_w1_done", done, 4'b0100);
    tick();

    // Core 0 reads 0x200; cores 0 and 3 report dirty, core 3 must be the source.
    cctrans    = 4'b0001;
    snoopdirty = 4'b1001;
    set_addr(0, 32'h200);
    set_data(0, 32'h0BAD_F00D);
    set_data(3, 32'hDEAD_BEEF);
    #1;
    check("t2_idle_done", done, 0);
    tick();
    check("t2_snoop_ccwait", ccwait, 4'b1110);
    tick();
    check("t2_w0_c2c", c2c, 1);
    check("t2_w0_dload", dload, 32'hDEAD_BEEF);
    check("t2_w0_dvalid", dvalid, 4'b0001);
    check("t2_w0_memreq", memreq, 0);
    check("t2_w0_xaddr", xaddr, 32'h200);
    check("t2_w0_ccwait", ccwait, 4'b1110);
    set_data(3, 32'hCAFE_F00D);
    tick();
    check("t2_w1_dload", dload, 32'hCAFE_F00D);
    check("t2_w1_xaddr", xaddr, 32'h204);
    check("t2_w1_done", done, 4'b0001);
    tick();

    // Core 1 write intent on 0x300; a dirty sharer moves no data here.
    cctrans    = 4'b0010;
    ccwrite    = 4'b0010;
    snoopdirty = 4'b0100;
    set_addr(1, 32'h300);
    #1;
    tick();
    check("t3_snoop_ccwait", ccwait, 4'b1101);
    check("t3_snoop_ccinv", ccinv, 0);
    tick();
    check("t3_inv_ccinv", ccinv, 4'b1101);
    check("t3_inv_ccwait", ccwait, 4'b1101);
    check("t3_inv_addr", ccsnoopaddr, 32'h300);
    check("t3_inv_done", done, 4'b0010);
    check("t3_inv_dvalid", dvalid, 0);
    check("t3_inv_c2c", c2c, 0);
    tick();
    check("t3_after_done", done, 0);

    // Core 3 reads 0x400 with memwait held for five cycles on word 0.
    cctrans    = 4'b1000;
    ccwrite    = 4'b0000;
    snoopdirty = 4'b0000;
    memwait    = 1'b1;
    set_addr(3, 32'h400);
    #1;
    tick();
    check("t4_snoop_ccwait", ccwait, 4'b0111);
    tick();
    set_addr(3, 32'h999);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      #1;
      check("t4_stall_dvalid", dvalid, 0);
      check("t4_stall_xaddr", xaddr, 32'h400);
      check("t4_stall_snoopaddr", ccsnoopaddr, 32'h400);
      check("t4_stall_memreq", memreq, 1);
    end
    memwait = 1'b0;
    #1;
    check("t4_w0_dvalid", dvalid, 4'b1000);
    check("t4_w0_xaddr", xaddr, 32'h400);
    check("t4_w0_done", done, 0);
    tick();
    check("t4_w1_xaddr", xaddr, 32'h404);
    check("t4_w1_done", done, 4'b1000);
    tick();

    // All four cores issue write intents and never drop cctrans.
    cctrans = 4'b1111;
    ccwrite = 4'b1111;
    for (int i = 0; i < NCPU; i++) set_addr(i, 32'h1000 + 32'(i) * 32'h100);
    #1;
    for (int g = 0; g < 5; g++) begin
      tick();
      check("arb_snoop_ccwait", ccwait, 4'hF & ~(4'b0001 << exp_grant[g]));
      check("arb_snoop_addr", ccsnoopaddr, 32'h1000 + 32'(exp_grant[g]) * 32'h100);
      tick();
      check("arb_inv_done", done, 4'b0001 << exp_grant[g]);
      tick();
    end
    cctrans = 4'b0000;
    ccwrite = 4'b0000;
    #1;
    check("arb_idle_dload", dload, 0);
    tick();
    check("arb_idle_ccwait", ccwait, 0);

    // Core 2 read 0x500 aborted by reset in word 1.
    cctrans = 4'b0100;
    set_addr(2, 32'h500);
    #1;
    tick();
    tick();
    check("t6_w0_xaddr", xaddr, 32'h500);
    tick();
    memwait = 1'b1;
    #1;
    check("t6_w1_xaddr", xaddr, 32'h504);
    check("t6_w1_done", done, 0);
    RST = 1'b1;
    #1;
    check("t6_rst_done", done, 0);
    check("t6_rst_memreq", memreq, 0);
    check("t6_rst_xaddr", xaddr, 0);
    check("t6_rst_snoopaddr", ccsnoopaddr, 0);
    tick();
    check("t6_rst_edge_done", done, 0);
    check("t6_rst_edge_dvalid", dvalid, 0);
    RST     = 1'b0;
    cctrans = 4'b0000;
    memwait = 1'b0;
    tick();
    check("t6_idle_ccwait", ccwait, 0);
    check("t6_idle_memreq", memreq, 0);

    // Normal operation resumes after reset.
    cctrans = 4'b0010;
    set_addr(1, 32'h600);
    #1;
    tick();
    check("t7_snoop_ccwait", ccwait, 4'b1101);
    tick();
    check("t7_w0_xaddr", xaddr, 32'h600);
    check("t7_w0_dvalid", dvalid, 4'b0010);
    tick();
    check("t7_w1_done", done, 4'b0010);
    cctrans = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
